// File: rtl/draw_pkg.sv
// Purpose : shared types and helpers for the draw command queue / frame-store controller.
// Latency : n/a (types and constant functions only).
// Backpressure: n/a.
// Contents: bank_t bank index, swap_state_t swap FSM states, fb_size() bank size helper,
//           third_bank() picks the bank that is neither of two given banks.
package draw_pkg;

   typedef logic [1:0] bank_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_VB = 2'd1,
      PEND    = 2'd2
   } swap_state_t;

   function automatic int fb_size(input int w, input int h);
      return w * h;
   endfunction

   // Banks are 0,1,2 so the remaining one is 3 minus the other two.
   function automatic bank_t third_bank(input bank_t a, input bank_t b);
      return 2'd3 - a - b;
   endfunction

endpackage

// File: rtl/draw_cmd_fifo.sv
// Purpose : synchronous count-based FIFO on an inferred 1R1W RAM; every entry usable.
// Latency : popped word and its valid pulse appear 1 cycle after an accepted pop.
// Backpressure: writes dropped while full (even with a same-cycle pop); reads ignored while empty.
// Ports   : clk, reset (sync, active-high); wr/wr_data push side, full and level registered;
//           rd pop request, rd_data/rd_valid result, empty registered.
module draw_cmd_fifo #(
   parameter int DATA_W     = 16,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr,
   input  logic [DATA_W-1:0]     wr_data,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   level,
   input  logic                  rd,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  rd_valid,
   output logic                  empty
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

   typedef logic [DEPTH_LOG2-1:0] ptr_t;

   logic [DATA_W-1:0]   mem [0:DEPTH-1];
   ptr_t                wr_ptr;
   ptr_t                rd_ptr;
   logic [DEPTH_LOG2:0] level_nxt;
   logic                push;
   logic                pop;

   // Gating uses the registered flags, so a full FIFO refuses a push even
   // when the same cycle frees a slot, and an empty one ignores a pop.
   assign push = wr & ~full;
   assign pop  = rd & ~empty;

   always_comb begin
      level_nxt = level;
      case ({push, pop})
         2'b10:   level_nxt = level + 1'b1;
         2'b01:   level_nxt = level - 1'b1;
         default: level_nxt = level;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         rd_valid <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ptr_t'(1);
         if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
         level    <= level_nxt;
         full     <= (level_nxt == LEVEL_FULL);
         empty    <= (level_nxt == '0);
         rd_valid <= pop;
      end
   end

   // RAM ports kept reset-free so they map onto block memory.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (pop) rd_data <= mem[rd_ptr];
   end

endmodule

// File: rtl/draw_queue_ctrl.sv
// Purpose : CPU->painter command queue plus double/triple-buffered frame-store bank control
//           with the displayed-bank flip locked to vertical blank.
// Latency : pq_data 1 cycle after pop; fb_waddr/fb_we/fb_raddr 1 cycle after inputs;
//           vblank seen 2 cycles after vsync_in falls, flip registered on the next edge.
// Backpressure: cpu_full drops pushes; swap_req while a flip is already owed is ignored.
// Ports   : clk, reset (sync, active-high); cpu_we/cpu_data/cpu_full/cpu_level CPU side;
//           pq_rd/pq_data/pq_valid/pq_empty painter queue; swap_req/swap_ack bank handshake;
//           vsync_in async active-low; pix_we/pix_addr -> fb_we/fb_waddr write map;
//           vga_line/vga_offset -> fb_raddr read map; front_bank/back_bank; ovf_count.
// Option  : define DRAW_QUEUE_OVF_COUNT_EN to count pushes dropped while full (saturating).
module draw_queue_ctrl
   import draw_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int DEPTH_LOG2 = 10,
   parameter int FB_W       = 160,
   parameter int FB_H       = 120,
   parameter int NUM_BANKS  = 2,
   parameter int ADDR_W     = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cpu_we,
   input  logic [DATA_W-1:0]   cpu_data,
   output logic                cpu_full,
   output logic [DEPTH_LOG2:0] cpu_level,
   input  logic                pq_rd,
   output logic [DATA_W-1:0]   pq_data,
   output logic                pq_valid,
   output logic                pq_empty,
   input  logic                swap_req,
   output logic                swap_ack,
   input  logic                vsync_in,
   input  logic                pix_we,
   input  logic [ADDR_W-1:0]   pix_addr,
   output logic                fb_we,
   output logic [ADDR_W-1:0]   fb_waddr,
   input  logic [6:0]          vga_line,
   input  logic [7:0]          vga_offset,
   output logic [ADDR_W-1:0]   fb_raddr,
   output logic [1:0]          front_bank,
   output logic [1:0]          back_bank,
   output logic [15:0]         ovf_count
);

   localparam int FB_SIZE = fb_size(FB_W, FB_H);
   localparam logic [ADDR_W-1:0] FB_SIZE_A = ADDR_W'(FB_SIZE);
   localparam logic [ADDR_W-1:0] FB_W_A    = ADDR_W'(FB_W);

   // ---------------- command queue ----------------
   draw_cmd_fifo #(
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr       (cpu_we),
      .wr_data  (cpu_data),
      .full     (cpu_full),
      .level    (cpu_level),
      .rd       (pq_rd),
      .rd_data  (pq_data),
      .rd_valid (pq_valid),
      .empty    (pq_empty)
   );

`ifdef DRAW_QUEUE_OVF_COUNT_EN
   logic [15:0] ovf_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q <= '0;
      end else if (cpu_we && cpu_full && (ovf_q != 16'hFFFF)) begin
         ovf_q <= ovf_q + 16'd1;
      end
   end

   assign ovf_count = ovf_q;
`else
   assign ovf_count = '0;
`endif

   // ---------------- vblank detect ----------------
   // Flops reset high (vsync idle level) so leaving reset never fakes an edge.
   logic vsync_meta;
   logic vsync_sync;
   logic vsync_prev;
   logic vblank_evt;

   always_ff @(posedge clk) begin
      if (reset) begin
         vsync_meta <= 1'b1;
         vsync_sync <= 1'b1;
         vsync_prev <= 1'b1;
      end else begin
         vsync_meta <= vsync_in;
         vsync_sync <= vsync_meta;
         vsync_prev <= vsync_sync;
      end
   end

   assign vblank_evt = vsync_prev & ~vsync_sync;

   // ---------------- swap FSM ----------------
   swap_state_t state, state_nxt;
   bank_t       front, front_nxt;
   bank_t       back, back_nxt;
   bank_t       pending, pending_nxt;
   logic        ack_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         front    <= 2'd0;
         back     <= 2'd1;
         pending  <= 2'd0;
         swap_ack <= 1'b0;
      end else begin
         state    <= state_nxt;
         front    <= front_nxt;
         back     <= back_nxt;
         pending  <= pending_nxt;
         swap_ack <= ack_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      front_nxt   = front;
      back_nxt    = back;
      pending_nxt = pending;
      ack_nxt     = 1'b0;
      if (NUM_BANKS == 3) begin
         // Triple: painter gets the free bank at once; the finished one is
         // held in 'pending' until vblank puts it on screen.
         case (state)
            IDLE: begin
               if (swap_req) begin
                  pending_nxt = back;
                  back_nxt    = third_bank(front, back);
                  ack_nxt     = 1'b1;
                  state_nxt   = PEND;
               end
            end
            PEND: begin
               if (vblank_evt) begin
                  front_nxt = pending;
                  state_nxt = IDLE;
                  // A request landing on the flip cycle is served as from
                  // IDLE against the new front, so it is not lost.
                  if (swap_req) begin
                     pending_nxt = back;
                     back_nxt    = third_bank(pending, back);
                     ack_nxt     = 1'b1;
                     state_nxt   = PEND;
                  end
               end else if (swap_req) begin
                  state_nxt = WAIT_VB;
               end
            end
            WAIT_VB: begin
               // No free bank: the painter waits for the displayed one.
               if (vblank_evt) begin
                  front_nxt   = pending;
                  pending_nxt = back;
                  back_nxt    = front;
                  ack_nxt     = 1'b1;
                  state_nxt   = PEND;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end else begin
         case (state)
            IDLE: begin
               if (swap_req) state_nxt = WAIT_VB;
            end
            WAIT_VB: begin
               if (vblank_evt) begin
                  front_nxt = back;
                  back_nxt  = front;
                  ack_nxt   = 1'b1;
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign front_bank = front;
   assign back_bank  = back;

   // ---------------- address maps ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         fb_we    <= 1'b0;
         fb_waddr <= '0;
         fb_raddr <= '0;
      end else begin
         fb_we    <= pix_we & (pix_addr < FB_SIZE_A);
         fb_waddr <= ADDR_W'(back) * FB_SIZE_A + pix_addr;
         fb_raddr <= ADDR_W'(front) * FB_SIZE_A
                     + ADDR_W'(vga_line) * FB_W_A
                     + ADDR_W'(vga_offset);
      end
   end

endmodule

// File: tb/tb_draw_queue_ctrl.sv
// Bench for draw_queue_ctrl: one double-buffered and one triple-buffered instance share the
// queue and pixel/VGA inputs; each has its own swap_req and vsync. A queue model and bank
// variables give the expected outputs every cycle.
module tb_draw_queue_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_we;
   logic [15:0] cpu_data;
   logic        pq_rd;
   logic        swap_req, swap_req3;
   logic        vsync_in, vsync3;
   logic        pix_we;
   logic [15:0] pix_addr;
   logic [6:0]  vga_line;
   logic [7:0]  vga_offset;

   logic        cpu_full, cpu_full3;
   logic [10:0] cpu_level, cpu_level3;
   logic [15:0] pq_data, pq_data3;
   logic        pq_valid, pq_valid3, pq_empty, pq_empty3;
   logic        swap_ack, swap_ack3;
   logic        fb_we, fb_we3;
   logic [15:0] fb_waddr, fb_waddr3, fb_raddr, fb_raddr3;
   logic [1:0]  front_bank, back_bank, front_bank3, back_bank3;
   logic [15:0] ovf_count, ovf_count3;

   always #5 clk = ~clk;

   draw_queue_ctrl dut (
      .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_data(cpu_data), .cpu_full(cpu_full),
      .cpu_level(cpu_level), .pq_rd(pq_rd), .pq_data(pq_data), .pq_valid(pq_valid),
      .pq_empty(pq_empty), .swap_req(swap_req), .swap_ack(swap_ack), .vsync_in(vsync_in),
      .pix_we(pix_we), .pix_addr(pix_addr), .fb_we(fb_we), .fb_waddr(fb_waddr),
      .vga_line(vga_line), .vga_offset(vga_offset), .fb_raddr(fb_raddr),
      .front_bank(front_bank), .back_bank(back_bank), .ovf_count(ovf_count)
   );

   draw_queue_ctrl #(.NUM_BANKS(3)) dut3 (
      .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_data(cpu_data), .cpu_full(cpu_full3),
      .cpu_level(cpu_level3), .pq_rd(pq_rd), .pq_data(pq_data3), .pq_valid(pq_valid3),
      .pq_empty(pq_empty3), .swap_req(swap_req3), .swap_ack(swap_ack3), .vsync_in(vsync3),
      .pix_we(pix_we), .pix_addr(pix_addr), .fb_we(fb_we3), .fb_waddr(fb_waddr3),
      .vga_line(vga_line), .vga_offset(vga_offset), .fb_raddr(fb_raddr3),
      .front_bank(front_bank3), .back_bank(back_bank3), .ovf_count(ovf_count3)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // reference state
   logic [15:0] mq[$];
   int ovf_m = 0;
   int m_front = 0, m_back = 1, m3_front = 0, m3_back = 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: derive expectations from the inputs now applied, advance, then compare.
   task automatic cycle();
      bit          rst_now, do_push, do_pop;
      int          sz;
      logic [15:0] pv;
      logic        exp_we;
      logic [15:0] exp_wa, exp_ra, exp_wa3, exp_ra3;
      rst_now = reset;
      sz      = mq.size();
      do_push = cpu_we && (sz < 1024);
      do_pop  = pq_rd && (sz > 0);
      exp_we  = pix_we && (int'(pix_addr) < 19200);
      exp_wa  = 16'(m_back * 19200 + int'(pix_addr));
      exp_wa3 = 16'(m3_back * 19200 + int'(pix_addr));
      exp_ra  = 16'(m_front * 19200 + int'(vga_line) * 160 + int'(vga_offset));
      exp_ra3 = 16'(m3_front * 19200 + int'(vga_line) * 160 + int'(vga_offset));
      pv      = 16'h0;
      if (rst_now) begin
         mq.delete();
         ovf_m = 0;
         m_front = 0; m_back = 1; m3_front = 0; m3_back = 1;
         do_pop = 0; exp_we = 0; exp_wa = 0; exp_ra = 0; exp_wa3 = 0; exp_ra3 = 0;
      end else begin
         if (do_pop)  pv = mq.pop_front();
         if (do_push) mq.push_back(cpu_data);
`ifdef DRAW_QUEUE_OVF_COUNT_EN
         if (cpu_we && sz == 1024 && ovf_m < 65535) ovf_m++;
`endif
      end
      @(posedge clk);
      #1;
      chk("level", 32'(cpu_level), 32'(mq.size()));
      chk("full", 32'(cpu_full), 32'(mq.size() == 1024));
      chk("empty", 32'(pq_empty), 32'(mq.size() == 0));
      chk("pq_valid", 32'(pq_valid), 32'(do_pop));
      if (do_pop) chk("pq_data", 32'(pq_data), 32'(pv));
      chk("ovf", 32'(ovf_count), 32'(ovf_m));
      chk("level3", 32'(cpu_level3), 32'(mq.size()));
      chk("pq_valid3", 32'(pq_valid3), 32'(do_pop));
      if (do_pop) chk("pq_data3", 32'(pq_data3), 32'(pv));
      chk("full3", 32'(cpu_full3), 32'(mq.size() == 1024));
      chk("empty3", 32'(pq_empty3), 32'(mq.size() == 0));
      chk("ovf3", 32'(ovf_count3), 32'(ovf_m));
      chk("fb_we", 32'(fb_we), 32'(exp_we));
      chk("fb_waddr", 32'(fb_waddr), 32'(exp_wa));
      chk("fb_raddr", 32'(fb_raddr), 32'(exp_ra));
      chk("fb_we3", 32'(fb_we3), 32'(exp_we));
      chk("fb_waddr3", 32'(fb_waddr3), 32'(exp_wa3));
      chk("fb_raddr3", 32'(fb_raddr3), 32'(exp_ra3));
   endtask

   task automatic chk_banks(input string tag);
      chk({tag, "_front"}, 32'(front_bank), 32'(m_front));
      chk({tag, "_back"}, 32'(back_bank), 32'(m_back));
      chk({tag, "_front3"}, 32'(front_bank3), 32'(m3_front));
      chk({tag, "_back3"}, 32'(back_bank3), 32'(m3_back));
   endtask

   initial begin
      int nxt, exp_seq, guard, ovf_exp;
      reset = 1'b1; cpu_we = 0; cpu_data = 0; pq_rd = 0;
      swap_req = 0; swap_req3 = 0; vsync_in = 1; vsync3 = 1;
      pix_we = 0; pix_addr = 0; vga_line = 0; vga_offset = 0;

      // ---- reset state ----
      cycle(); cycle();
      chk_banks("reset");
      chk("reset_ack", 32'(swap_ack), 32'd0);
      chk("reset_ack3", 32'(swap_ack3), 32'd0);
      reset = 1'b0;
      cycle();

      // ---- fill to full, then one dropped push ----
      for (int i = 0; i < 1024; i++) begin
         cpu_we = 1; cpu_data = 16'($urandom);
         cycle();
      end
      chk("fill_full", 32'(cpu_full), 32'd1);
      chk("fill_level", 32'(cpu_level), 32'd1024);
      cpu_data = 16'hDEAD;
      cycle();
`ifdef DRAW_QUEUE_OVF_COUNT_EN
      ovf_exp = 1;
`else
      ovf_exp = 0;
`endif
      chk("ovf_after_drop", 32'(ovf_count), 32'(ovf_exp));
      chk("level_after_drop", 32'(cpu_level), 32'd1024);

      // ---- full + push + pop: push dropped, pop taken ----
      pq_rd = 1; cpu_data = 16'hBEEF;
      cycle();
      chk("full_pushpop_level", 32'(cpu_level), 32'd1023);
      cpu_we = 0;
      for (int i = 0; i < 1030; i++) cycle();   // drain plus pops on empty
      chk("drained_empty", 32'(pq_empty), 32'd1);

      // ---- empty + push + pop: pop ignored ----
      cpu_we = 1; cpu_data = 16'h1234;
      cycle();
      chk("empty_pushpop_level", 32'(cpu_level), 32'd1);
      chk("empty_pushpop_valid", 32'(pq_valid), 32'd0);
      cpu_we = 0;
      cycle();
      chk("empty_pushpop_data", 32'(pq_data), 32'h1234);
      pq_rd = 0;
      cycle();

      // ---- order across pointer wrap ----
      nxt = 1; exp_seq = 1; guard = 0;
      while (exp_seq <= 16'h600 && guard < 8000) begin
         cpu_we   = (nxt <= 16'h600) && ($urandom_range(0, 3) != 0);
         cpu_data = 16'(nxt);
         pq_rd    = ($urandom_range(0, 2) != 0);
         if (cpu_we && mq.size() < 1024) nxt++;
         cycle();
         if (pq_valid) begin
            chk("order", 32'(pq_data), 32'(exp_seq));
            exp_seq++;
         end
         guard++;
      end
      chk("order_complete", 32'(exp_seq), 32'h601);
      cpu_we = 0; pq_rd = 0;

      // ---- random queue traffic ----
      for (int i = 0; i < 1500; i++) begin
         cpu_we = ($urandom_range(0, 1) == 1); cpu_data = 16'($urandom);
         pq_rd  = ($urandom_range(0, 2) == 0);
         cycle();
      end
      cpu_we = 0; pq_rd = 0;

      // ---- double buffer ----
      pix_we = 1; pix_addr = 5;
      cycle();
      chk("pre_swap_waddr", 32'(fb_waddr), 32'd19205);
      pix_we = 0;
      repeat (8) cycle();
      swap_req = 1;
      cycle();
      swap_req = 0;
      repeat (80) cycle();
      chk("db_no_ack_before_vb", 32'(swap_ack), 32'd0);
      chk_banks("db_wait");
      vsync_in = 0;
      cycle(); cycle();
      chk("db_ack_not_yet", 32'(swap_ack), 32'd0);
      cycle();
      chk("db_ack", 32'(swap_ack), 32'd1);
      m_front = 1; m_back = 0;
      chk_banks("db_flip");
      vsync_in = 1;
      cycle();
      chk("db_ack_pulse", 32'(swap_ack), 32'd0);
      pix_we = 1; pix_addr = 5;
      cycle();
      chk("post_swap_waddr", 32'(fb_waddr), 32'd5);
      pix_we = 0;

      // ---- triple buffer ----
      swap_req3 = 1;
      cycle();
      swap_req3 = 0;
      chk("tb_ack_next", 32'(swap_ack3), 32'd1);
      m3_back = 2;
      chk_banks("tb_req1");
      cycle();
      chk("tb_ack_pulse", 32'(swap_ack3), 32'd0);
      repeat (5) cycle();
      swap_req3 = 1;
      cycle();
      swap_req3 = 0;
      chk("tb_req2_no_ack", 32'(swap_ack3), 32'd0);
      repeat (5) cycle();
      chk("tb_req2_still_no_ack", 32'(swap_ack3), 32'd0);
      vsync3 = 0;
      cycle(); cycle();
      chk("tb_front_held", 32'(front_bank3), 32'd0);
      cycle();
      chk("tb_ack_vb", 32'(swap_ack3), 32'd1);
      m3_front = 1; m3_back = 0;
      chk_banks("tb_flip1");
      vsync3 = 1;
      repeat (4) cycle();
      vsync3 = 0;
      cycle(); cycle(); cycle();
      m3_front = 2;
      chk_banks("tb_flip2");
      chk("tb_flip2_no_ack", 32'(swap_ack3), 32'd0);
      vsync3 = 1;

      // ---- random address maps ----
      for (int i = 0; i < 300; i++) begin
         pix_we = ($urandom_range(0, 1) == 1);
         pix_addr = 16'($urandom_range(0, 19300));
         vga_line = 7'($urandom_range(0, 119));
         vga_offset = 8'($urandom_range(0, 159));
         cycle();
      end
      pix_we = 0; pix_addr = 0; vga_line = 0; vga_offset = 0;

      // ---- reset during WAIT_VB ----
      swap_req = 1;
      cycle();
      swap_req = 0;
      cycle();
      reset = 1;
      cycle(); cycle();
      reset = 0;
      vsync_in = 0;
      for (int i = 0; i < 6; i++) begin
         cycle();
         chk("rst_no_ack", 32'(swap_ack), 32'd0);
      end
      chk_banks("rst_banks");
      vsync_in = 1;
      pix_we = 1; pix_addr = 16'd19200; vga_line = 7'd3; vga_offset = 8'd7;
      cycle();
      chk("oob_we", 32'(fb_we), 32'd0);
      chk("raddr_487", 32'(fb_raddr), 32'd487);
      pix_we = 0;
      cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
